// File: rtl/pu_layer_ctrl.sv
`default_nettype none
// pu_layer_ctrl: time-multiplexes one 8-input neuron processing unit over every neuron of a layer.
// Revision 1.0
module pu_layer_ctrl #(
  parameter int size    = 16,
  parameter int NEURONS = 8,
  parameter int RELU    = 1,
  parameter int AW      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [8*size-1:0] x_in,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [8*size-1:0] mem_w,
  input  logic [size-1:0]   mem_b,
  output logic [8*size-1:0] pu_x,
  output logic [8*size-1:0] pu_w,
  output logic [size-1:0]   pu_bias,
  input  logic [size-1:0]   pu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [AW-1:0]     res_idx,
  output logic [size-1:0]   res_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EVAL  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NEURONS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            accept;
  logic            handshake;
  logic            last_neuron;
  logic            clamp;
  logic [size-1:0] eval_data;

  assign accept      = (state == S_IDLE) && start;
  assign handshake   = (state == S_WRITE) && res_ready;
  assign last_neuron = (cnt == LAST_IDX);
  assign clamp       = (RELU != 0) && pu_out[size-1];
  assign eval_data   = clamp ? '0 : pu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mem_rd    = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = last_neuron ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // mem_addr is loaded on every entry to FETCH so it equals the counter there and holds elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mem_addr <= '0;
      pu_x     <= '0;
      pu_w     <= '0;
      pu_bias  <= '0;
      res_idx  <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        pu_x     <= x_in;
        cnt      <= '0;
        mem_addr <= '0;
      end
      if (state == S_LOAD) begin
        pu_w    <= mem_w;
        pu_bias <= mem_b;
      end
      if (state == S_EVAL) begin
        res_data <= eval_data;
        res_idx  <= cnt;
      end
      if (handshake && !last_neuron) begin
        cnt      <= cnt + 1'b1;
        mem_addr <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
